// File: rtl/seed_random4_data_path.sv
`default_nettype none
// ============================================================================
// Module   : seed_random4_data_path
// Brief    : Free-running 16-bit LFSR card generator; emits a registered
//            8-bit card code (rank, optional suit) on each request cycle.
//            Optional macro: SEED_RANDOM_SUIT_EN (drives suit onto bits [5:4]).
// Revision : 1.0 - initial release
// ============================================================================
module seed_random4_data_path #(
    parameter int                    LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] SEED       = 16'hACE1
) (
    input  logic       clk_dp_i,
    input  logic       rst_dp_i,
    input  logic       req_card_state_dp_i,
    output logic [7:0] card_to_send_dp_o
);

    localparam logic [3:0] c_RANK_WRAP = 4'd13;

    logic [LFSR_WIDTH-1:0] r_lfsr;
    logic [7:0]            r_card;
    logic                  w_fb;
    logic [LFSR_WIDTH-1:0] w_lfsr_next;
    logic [3:0]            w_raw;
    logic [3:0]            w_rank;
    logic [1:0]            w_suit;
    logic [7:0]            w_card;

    // Taps 16,14,13,11; an all-zero state would stick, so reload the seed.
    always_comb begin
        w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
        w_lfsr_next = (r_lfsr == '0) ? SEED : {r_lfsr[LFSR_WIDTH-2:0], w_fb};
    end

    // Card fields come from the pre-shift LFSR value; 13..15 fold onto 1..3.
    always_comb begin
        w_raw  = r_lfsr[3:0];
        w_rank = (w_raw >= c_RANK_WRAP) ? (w_raw - 4'd12) : (w_raw + 4'd1);
`ifdef SEED_RANDOM_SUIT_EN
        w_suit = r_lfsr[5:4];
`else
        w_suit = 2'b00;
`endif
        w_card = {2'b00, w_suit, w_rank};
    end

    always_ff @(posedge clk_dp_i) begin
        if (rst_dp_i) begin
            r_lfsr <= SEED;
            r_card <= 8'h00;
        end else begin
            r_lfsr <= w_lfsr_next;
            if (req_card_state_dp_i) begin
                r_card <= w_card;
            end
        end
    end

    assign card_to_send_dp_o = r_card;

endmodule
`default_nettype wire

// File: tb/tb_seed_random4_data_path.sv
`default_nettype none
// ============================================================================
// Module   : tb_seed_random4_data_path
// Brief    : Self-checking bench for seed_random4_data_path against an
//            arithmetic reference model of the card generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seed_random4_data_path;

    localparam int c_SEED = 16'hACE1;
`ifdef SEED_RANDOM_SUIT_EN
    localparam logic [7:0] c_FIRST_CARD = 8'h22;
`else
    localparam logic [7:0] c_FIRST_CARD = 8'h02;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic [7:0] card;

    int         model_lfsr = c_SEED;
    logic [7:0] model_card = 8'h00;
    int         errors = 0;
    int         checks = 0;

    seed_random4_data_path dut (
        .clk_dp_i            (clk),
        .rst_dp_i            (rst),
        .req_card_state_dp_i (req),
        .card_to_send_dp_o   (card)
    );

    always #5 clk = ~clk;

    // Next state: shift left, feedback = parity of bits 15,13,12,10 (mask 0xB400).
    function automatic int lfsr_next(input int s);
        int fb;
        if (s == 0) return c_SEED;
        fb = $countones(s & 16'hB400) % 2;
        return ((s * 2) + fb) % 65536;
    endfunction

    function automatic logic [7:0] card_of(input int s);
        int rank;
        int suit;
        rank = ((s % 16) % 13) + 1;
`ifdef SEED_RANDOM_SUIT_EN
        suit = (s / 16) % 4;
`else
        suit = 0;
`endif
        return 8'(suit * 16 + rank);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance the model with pre-edge state, sample after.
    task automatic step(input logic r, input logic q);
        @(negedge clk);
        rst = r;
        req = q;
        @(posedge clk);
        if (r) begin
            model_lfsr = c_SEED;
            model_card = 8'h00;
        end else begin
            if (q) model_card = card_of(model_lfsr);
            model_lfsr = lfsr_next(model_lfsr);
        end
        #1;
    endtask

    task automatic check_legal(input string tag);
        check({tag, "_top"}, {6'b0, card[7:6]}, 8'h00);
        check({tag, "_rank_ok"}, {7'b0, (card[3:0] >= 4'd1 && card[3:0] <= 4'd13)}, 8'h01);
    endtask

    initial begin
        int found;
        int targets [3];
        int ranks   [3];
        targets = '{12, 13, 15};
        ranks   = '{13, 1, 3};

        // Reset and first card straight after release.
        step(1'b1, 1'b0);
        check("reset_out", card, 8'h00);
        step(1'b0, 1'b1);
        check("first_card", card, c_FIRST_CARD);
        check("first_card_model", card, model_card);

        // Idle hold for 10 cycles, then one request.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            check("hold", card, c_FIRST_CARD);
        end
        step(1'b0, 1'b1);
        check("after_idle", card, model_card);

        // 30 back-to-back requests.
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b1);
            check("b2b", card, model_card);
            check_legal("b2b");
        end

        // Random request pattern.
        for (int i = 0; i < 80; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)));
            check("rand", card, model_card);
        end
        check_legal("rand_end");

        // Rank boundaries: idle until the model LFSR low nibble hits the target.
        for (int t = 0; t < 3; t++) begin
            found = 0;
            for (int i = 0; i < 400 && found == 0; i++) begin
                if ((model_lfsr % 16) == targets[t]) found = 1;
                else step(1'b0, 1'b0);
            end
            check("boundary_reached", 8'(found), 8'h01);
            step(1'b0, 1'b1);
            check("boundary_card", card, model_card);
            check("boundary_rank", {4'h0, card[3:0]}, 8'(ranks[t]));
        end

        // Reset together with a request wins; next request repeats the first card.
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        check("reset_with_req", card, 8'h00);
        step(1'b0, 1'b1);
        check("post_reset_card", card, c_FIRST_CARD);
        step(1'b0, 1'b0);
        check("post_reset_hold", card, c_FIRST_CARD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
